// File: rtl/xor32_descrambler_if.sv
// Handshake bundle for the XOR descrambler.
//   in_valid/in_data/in_ready    : scrambled word stream from the source
//   out_valid/out_data/out_ready : descrambled word stream to the consumer
// slave  : the descrambler's view (accepts input, drives output)
// master : the environment's view (drives input, consumes output)
interface xor32_descrambler_if;
  localparam int unsigned DATA_W = 32;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/xor32_descrambler.sv
// Receive-side XOR descrambler: out_data = in_data ^ key, where key is the
// state of a 32-bit Fibonacci LFSR that steps once per accepted word.
// One registered output stage, latency 1, full throughput with backpressure.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   seed_we/seed : load LFSR seed (zero seed maps to 1), clears pending word
//   bus          : in_* / out_* valid-ready handshakes (slave modport)
//   locked       : block has been seeded and is running
//   word_cnt     : words accepted since the last seed or reset (wraps)
module xor32_descrambler #(
  parameter logic [31:0] TAPS  = 32'h80200003,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_we,
  input  logic [31:0]          seed,
  xor32_descrambler_if.slave   bus,
  output logic                 locked,
  output logic [CNT_W-1:0]     word_cnt
);

  localparam int unsigned DATA_W = 32;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [DATA_W-1:0] lfsr;
  logic [DATA_W-1:0] lfsr_nxt;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic              accept_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: any seed load starts (or restarts) the keystream
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (seed_we) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready only when running, not seeding, and the output slot is free or draining
  assign bus.in_ready = (state == RUN) && !seed_we && (!out_valid_q || bus.out_ready);
  assign accept_c     = bus.in_valid && bus.in_ready;

  // Fibonacci step: feedback is the parity of the tapped bits, shifted in at bit 0
  assign lfsr_nxt = {lfsr[DATA_W-2:0], ^(lfsr & TAPS)};

  // Keystream, output register and word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      word_cnt_q  <= '0;
    end else if (seed_we) begin
      // All-zero state would lock the LFSR, so a zero seed is mapped to 1
      lfsr        <= (seed == '0) ? DATA_W'(1) : seed;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
    end else if (accept_c) begin
      out_data_q  <= bus.in_data ^ lfsr;
      out_valid_q <= 1'b1;
      lfsr        <= lfsr_nxt;
      word_cnt_q  <= word_cnt_q + CNT_W'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign word_cnt      = word_cnt_q;
  assign locked        = (state == RUN);

endmodule

// File: tb/tb_xor32_descrambler.sv
// Directed and loopback bench for xor32_descrambler. A transaction-level
// model tracks the expected outputs; a negedge process compares every cycle.
module tb_xor32_descrambler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_we = 1'b0;
  logic [31:0] seed = '0;
  logic        locked;
  logic [15:0] word_cnt;

  xor32_descrambler_if bus ();

  xor32_descrambler #(.TAPS(32'h80200003), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .seed_we  (seed_we),
    .seed     (seed),
    .bus      (bus),
    .locked   (locked),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Polynomial x^32+x^22+x^2+x+1 written as a parity sum of the tapped bits
  function automatic logic [31:0] step(input logic [31:0] s);
    int unsigned ones;
    ones = ((s >> 31) & 1) + ((s >> 21) & 1) + ((s >> 1) & 1) + (s & 1);
    return (s << 1) | 32'(ones % 2);
  endfunction

  // Reference model, evaluated on each rising edge from the driven inputs
  logic        chk_en = 1'b0;
  logic        m_locked = 1'b0;
  logic [31:0] m_key = '0;
  logic        m_ov = 1'b0;
  logic [31:0] m_od = '0;
  logic [15:0] m_cnt = '0;
  logic        m_acc = 1'b0;

  always @(posedge clk) begin
    m_acc = 1'b0;
    if (rst) begin
      chk_en   = 1'b1;
      m_locked = 1'b0;
      m_key    = '0;
      m_ov     = 1'b0;
      m_od     = '0;
      m_cnt    = '0;
    end else if (seed_we) begin
      m_locked = 1'b1;
      m_key    = (seed == 0) ? 32'd1 : seed;
      m_ov     = 1'b0;
      m_cnt    = '0;
    end else if (m_locked && bus.in_valid && (!m_ov || bus.out_ready)) begin
      m_acc = 1'b1;
      m_od  = bus.in_data ^ m_key;
      m_ov  = 1'b1;
      m_key = step(m_key);
      m_cnt = m_cnt + 16'd1;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 1'b0;
    end
  end

  // Loopback scoreboard of plaintext in acceptance order
  logic        lb_on = 1'b0;
  logic [31:0] pq[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(bus.in_ready),
          32'(m_locked && !seed_we && (!m_ov || bus.out_ready)));
      chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("out_data", bus.out_data, m_od);
      chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
      chk("locked", 32'(locked), 32'(m_locked));
      if (lb_on && bus.out_valid && bus.out_ready) begin
        if (pq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL loopback: output %08h with no plaintext pending", bus.out_data);
        end else begin
          chk("loopback", bus.out_data, pq.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] w[3];
  logic [31:0] e[3];
  logic [31:0] cur_plain;
  logic [31:0] tx_key;
  int          sent;
  int          presented;
  int          cycles;

  initial begin
    w[0] = 32'h0000FFFF; w[1] = 32'h00FF00FF; w[2] = 32'h12345678;
    e[0] = 32'h0000FFFE; e[1] = 32'h00FF00FC; e[2] = 32'h1234567E;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // 1: reset, then traffic with no seed is ignored
    cyc(); cyc();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    cyc(); cyc();
    @(negedge clk);
    chk("t1 in_ready", 32'(bus.in_ready), 32'd0);
    chk("t1 out_valid", 32'(bus.out_valid), 32'd0);
    chk("t1 locked", 32'(locked), 32'd0);
    chk("t1 word_cnt", 32'(word_cnt), 32'd0);
    chk("t1 out_data", bus.out_data, 32'd0);

    // 2: seed 1, three words back-to-back
    cyc();
    bus.in_valid = 1'b0;
    seed_we = 1'b1; seed = 32'h1;
    cyc();
    seed_we = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = w[0];
    cyc();
    for (int i = 1; i < 3; i++) begin
      bus.in_data = w[i];
      @(negedge clk);
      chk("t2 out_data", bus.out_data, e[i-1]);
      cyc();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t2 out_data", bus.out_data, e[2]);
    chk("t2 word_cnt", 32'(word_cnt), 32'd3);
    chk("t2 model key", m_key, 32'h0000000D);
    cyc();

    // 3: backpressure holds output and freezes the keystream
    seed_we = 1'b1; seed = 32'h1;
    cyc();
    seed_we = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = w[0];
    cyc();
    bus.out_ready = 1'b0;
    bus.in_data   = w[1];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3 held data", bus.out_data, 32'h0000FFFE);
      chk("t3 in_ready", 32'(bus.in_ready), 32'd0);
      cyc();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t3 release ready", 32'(bus.in_ready), 32'd1);
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t3 second word", bus.out_data, 32'h00FF00FC);
    cyc();

    // 4: zero seed maps to key 1; re-seed drops pending word and input
    seed_we = 1'b1; seed = 32'h0;
    cyc();
    seed_we = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0;
    cyc();
    bus.in_data = 32'hCAFEF00D;
    seed_we = 1'b1; seed = 32'h5;
    @(negedge clk);
    chk("t4 zero seed key", bus.out_data, 32'h00000001);
    chk("t4 reseed in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    seed_we = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t4 reseed out_valid", 32'(bus.out_valid), 32'd0);
    chk("t4 reseed word_cnt", 32'(word_cnt), 32'd0);
    cyc();

    // 5: loopback against a bench-side scrambler with random gaps
    seed_we = 1'b1; seed = 32'hACE1ACE1;
    tx_key  = 32'hACE1ACE1;
    lb_on   = 1'b1;
    cyc();
    seed_we   = 1'b0;
    sent      = 0;
    presented = 0;
    cycles    = 0;
    while (sent < 1000 && cycles < 20000) begin
      if (m_acc) begin
        pq.push_back(cur_plain);
        sent++;
        bus.in_valid = 1'b0;
      end
      if (!bus.in_valid && presented < 1000 && $urandom_range(0, 3) != 0) begin
        cur_plain    = $urandom;
        bus.in_data  = cur_plain ^ tx_key;
        tx_key       = step(tx_key);
        bus.in_valid = 1'b1;
        presented++;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
      cycles++;
    end
    if (sent < 1000) begin
      n_vec++; n_err++;
      $display("FAIL loopback timeout: accepted %0d of 1000", sent);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycles = 0;
    while ((pq.size() != 0 || bus.out_valid) && cycles < 100) begin
      cyc();
      cycles++;
    end
    @(negedge clk);
    chk("t5 drained", 32'(pq.size()), 32'd0);
    chk("t5 word_cnt", 32'(word_cnt), 32'd1000);
    lb_on = 1'b0;
    cyc();

    // 6: reset with a word pending
    seed_we = 1'b1; seed = 32'h1;
    cyc();
    seed_we = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = w[0];
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t6 pending", 32'(bus.out_valid), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    chk("t6 out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6 locked", 32'(locked), 32'd0);
    chk("t6 in_ready", 32'(bus.in_ready), 32'd0);
    cyc(); cyc();
    @(negedge clk);
    chk("t6 word_cnt", 32'(word_cnt), 32'd0);
    chk("t6 still idle", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
